// File: rtl/spm_pkg.sv
// Shared types and sizing for the spm bit-serial host controller.
// No datapath or flow control here; latency and backpressure belong to the users.
package spm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } spm_ctrl_state_e;

  localparam int SPM_N_DEFAULT = 32;

  function automatic int spm_cnt_w(input int n, input int p_lat);
    return $clog2(2 * n + p_lat);
  endfunction

endpackage

// File: rtl/spm_sipo.sv
// Serial-in parallel-out capture register; one bit per enabled cycle, entering at the MSB.
// Latency 1 cycle per bit; no backpressure (the caller gates with en).
module spm_sipo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = {din, q_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/spm_serial_ctrl.sv
// Host end of the spm bit-serial link: drives x in parallel and y LSB-first, collects the product.
// Accept to out_valid is 2N+P_LAT+2 cycles; one op in flight, result held until out_ready.
module spm_serial_ctrl
  import spm_pkg::*;
#(
  parameter int N     = SPM_N_DEFAULT,
  parameter int P_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_y,
  input  logic           in_signed,
  output logic [N-1:0]   spm_x,
  output logic           spm_y,
  output logic           spm_rst,
  input  logic           spm_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p
);

  localparam int CW = spm_cnt_w(N, P_LAT);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(2 * N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(P_LAT);

  spm_ctrl_state_e state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    spm_x_q, spm_x_d;
  logic [N-1:0]    y_sh_q, y_sh_d;
  logic            sgn_q, sgn_d;
  logic            spm_y_q, spm_y_d;
  logic            spm_rst_q, spm_rst_d;
  // bit 0 marks a live y bit on spm_y; bit P_LAT marks its product bit on spm_p
  logic [P_LAT:0]  vld_q, vld_d;
  logic            cap_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    spm_x_d = spm_x_q;
    y_sh_d  = y_sh_q;
    sgn_d   = sgn_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          spm_x_d = in_x;
          y_sh_d  = in_y;
          sgn_d   = in_signed;
          state_d = CLR;
        end
      end
      CLR: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        // arithmetic right shift supplies the sign extension for the upper N bits
        y_sh_d = {sgn_q & y_sh_q[N-1], y_sh_q[N-1:1]};
        if (cnt_q == SHIFT_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        // one cycle beyond P_LAT covers the registered spm_y stage
        if (cnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spm_y_d   = (state_q == SHIFT) & y_sh_q[0];
    spm_rst_d = (state_q != CLR);
    vld_d     = '0;
    vld_d[0]  = (state_q == SHIFT);
    for (int i = 1; i <= P_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      spm_x_q   <= '0;
      y_sh_q    <= '0;
      sgn_q     <= 1'b0;
      spm_y_q   <= 1'b0;
      spm_rst_q <= 1'b0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      spm_x_q   <= spm_x_d;
      y_sh_q    <= y_sh_d;
      sgn_q     <= sgn_d;
      spm_y_q   <= spm_y_d;
      spm_rst_q <= spm_rst_d;
      vld_q     <= vld_d;
    end
  end

  assign cap_en = vld_q[P_LAT];

  spm_sipo #(
    .W(2 * N)
  ) u_sipo (
    .clk  (clk),
    .rst_n(rst),
    .clr  (state_q == CLR),
    .en   (cap_en),
    .din  (spm_p),
    .q    (out_p)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign spm_x     = spm_x_q;
  assign spm_y     = spm_y_q;
  assign spm_rst   = spm_rst_q;

endmodule

// File: tb/tb_spm_serial_ctrl.sv
// Directed bench for spm_serial_ctrl (N=8, P_LAT=1) with a behavioural serial-parallel multiplier.
module tb_spm_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic        in_signed;
  logic [7:0]  spm_x;
  logic        spm_y;
  logic        spm_rst;
  logic        spm_p;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;

  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  spm_serial_ctrl #(.N(8), .P_LAT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_signed(in_signed),
    .spm_x    (spm_x),
    .spm_y    (spm_y),
    .spm_rst  (spm_rst),
    .spm_p    (spm_p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p)
  );

  // Behavioural spm: product bit k appears on spm_p the cycle after y bit k
  logic        tb_signed;
  logic [15:0] m_acc;
  logic [15:0] m_xext;
  logic [15:0] m_nxt;
  int          m_k;

  assign m_xext = tb_signed ? {{8{spm_x[7]}}, spm_x} : {8'h00, spm_x};
  assign m_nxt  = m_acc + (spm_y ? (m_xext << m_k) : 16'h0000);

  always @(posedge clk) begin
    if (!spm_rst) begin
      m_acc <= 16'h0000;
      m_k   <= 0;
      spm_p <= 1'b0;
    end else if (m_k < 16) begin
      m_acc <= m_nxt;
      spm_p <= m_nxt[m_k];
      m_k   <= m_k + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] r_p;
  int          r_lat;
  int          r_clrs;
  logic [15:0] r_ytr;
  logic        r_yafter;

  // Runs one operation from accept until out_valid is seen; leaves DONE for the caller.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic keep_valid);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    in_x = x; in_y = y; in_signed = s; tb_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    if (keep_valid) begin
      in_x = ~x; in_y = ~y;
    end else begin
      in_valid = 1'b0;
    end
    r_lat = 0; r_clrs = 0; r_ytr = 16'h0000; r_yafter = 1'b1;
    while (!out_valid && r_lat < 200) begin
      @(posedge clk); #1; r_lat++;
      if (!spm_rst) r_clrs++;
      if (r_lat >= 2 && r_lat < 18) r_ytr[r_lat-2] = spm_y;
      if (r_lat == 18) r_yafter = spm_y;
    end
    r_p = out_p;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_x = 8'h00; in_y = 8'h00; in_signed = 1'b0;
    out_ready = 1'b0; tb_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    check_cnt++; if (out_p !== 16'h0000) $display("FAIL reset_out_p: got %h expected 0000", out_p); else pass_cnt++;
    check_cnt++; if (spm_x !== 8'h00 || spm_y !== 1'b0) $display("FAIL reset_spm_xy: got x=%h y=%b expected 00/0", spm_x, spm_y); else pass_cnt++;
    check_cnt++; if (spm_rst !== 1'b0) $display("FAIL reset_spm_rst: got %b expected 0", spm_rst); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    check_cnt++; if (spm_rst !== 1'b1) $display("FAIL release_spm_rst: got %b expected 1", spm_rst); else pass_cnt++;
  endtask

  task automatic test_unsigned();
    run_op(8'd3, 8'd5, 1'b0, 1'b0);
    check_cnt++; if (r_p !== 16'h000F) $display("FAIL unsigned_3x5: got %h expected 000f", r_p); else pass_cnt++;
    check_cnt++; if (r_lat !== 19) $display("FAIL latency: got %0d expected 19", r_lat); else pass_cnt++;
    check_cnt++; if (r_clrs !== 1) $display("FAIL clr_once: got %0d expected 1", r_clrs); else pass_cnt++;
    check_cnt++; if (r_ytr !== 16'h0005) $display("FAIL unsigned_ytrace: got %h expected 0005", r_ytr); else pass_cnt++;
    finish_op();
  endtask

  task automatic test_signed();
    run_op(8'hFD, 8'd5, 1'b1, 1'b0);
    check_cnt++; if (r_p !== 16'hFFF1) $display("FAIL signed_m3x5: got %h expected fff1", r_p); else pass_cnt++;
    finish_op();
    run_op(8'd5, 8'hFD, 1'b1, 1'b0);
    check_cnt++; if (r_p !== 16'hFFF1) $display("FAIL signed_5xm3: got %h expected fff1", r_p); else pass_cnt++;
    check_cnt++; if (r_ytr !== 16'hFFFD) $display("FAIL signed_ytrace: got %h expected fffd (tail all 1s)", r_ytr); else pass_cnt++;
    check_cnt++; if (r_yafter !== 1'b0) $display("FAIL spm_y_after_shift: got %b expected 0", r_yafter); else pass_cnt++;
    finish_op();
  endtask

  task automatic test_extremes();
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    check_cnt++; if (r_p !== 16'hFE01) $display("FAIL unsigned_ffxff: got %h expected fe01", r_p); else pass_cnt++;
    check_cnt++; if (r_ytr !== 16'h00FF) $display("FAIL unsigned_ytail_zero: got %h expected 00ff", r_ytr); else pass_cnt++;
    finish_op();
    out_ready = 1'b1;
    run_op(8'h80, 8'h80, 1'b1, 1'b0);
    check_cnt++; if (r_p !== 16'h4000) $display("FAIL signed_80x80: got %h expected 4000", r_p); else pass_cnt++;
    check_cnt++; if (r_lat !== 19) $display("FAIL early_out_ready_latency: got %0d expected 19", r_lat); else pass_cnt++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL accept_drop: got valid=%b ready=%b expected 0/1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    run_op(8'd6, 8'd9, 1'b0, 1'b1);
    check_cnt++; if (r_p !== 16'h0036) $display("FAIL bp_product: got %h expected 0036", r_p); else pass_cnt++;
    check_cnt++; if (spm_x !== 8'd6) $display("FAIL bp_spm_x_held: got %h expected 06", spm_x); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_cnt++;
      if (out_valid !== 1'b1 || out_p !== 16'h0036 || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: got valid=%b p=%h ready=%b expected 1/0036/0", i, out_valid, out_p, in_ready);
      else pass_cnt++;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    in_x = 8'd9; in_y = 8'd9; in_signed = 1'b0; tb_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midrst_hs: got ready=%b valid=%b expected 1/0", in_ready, out_valid); else pass_cnt++;
    check_cnt++; if (spm_rst !== 1'b0) $display("FAIL midrst_spm_rst: got %b expected 0", spm_rst); else pass_cnt++;
    check_cnt++; if (spm_x !== 8'h00 || out_p !== 16'h0000) $display("FAIL midrst_clear: got x=%h p=%h expected 00/0000", spm_x, out_p); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(8'd2, 8'd7, 1'b0, 1'b0);
    check_cnt++; if (r_p !== 16'h000E) $display("FAIL midrst_next_op: got %h expected 000e", r_p); else pass_cnt++;
    finish_op();
  endtask

  task automatic test_back_to_back();
    run_op(8'd3, 8'd5, 1'b0, 1'b1);
    check_cnt++; if (r_p !== 16'h000F) $display("FAIL b2b_op1: got %h expected 000f", r_p); else pass_cnt++;
    check_cnt++; if (r_clrs !== 1) $display("FAIL b2b_op1_clr: got %0d expected 1", r_clrs); else pass_cnt++;
    in_x = 8'd2; in_y = 8'd7; out_ready = 1'b1;
    check_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_no_same_cycle: got in_ready=%b expected 0", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_gap: got ready=%b valid=%b expected 1/0", in_ready, out_valid); else pass_cnt++;
    check_cnt++; if (spm_rst !== 1'b1) $display("FAIL b2b_gap_spm_rst: got %b expected 1", spm_rst); else pass_cnt++;
    run_op(8'd2, 8'd7, 1'b0, 1'b0);
    check_cnt++; if (r_p !== 16'h000E) $display("FAIL b2b_op2: got %h expected 000e", r_p); else pass_cnt++;
    check_cnt++; if (r_clrs !== 1) $display("FAIL b2b_op2_clr: got %0d expected 1", r_clrs); else pass_cnt++;
    check_cnt++; if (r_lat !== 19) $display("FAIL b2b_op2_latency: got %0d expected 19", r_lat); else pass_cnt++;
    finish_op();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_extremes();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
